// File: rtl/snn_pkg.sv
// Shared types and default sizing for the spiking-network output stages.
package snn_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StScan
  } state_e;

  localparam int unsigned DefNNeurons = 8;
  localparam int unsigned DefWindow   = 16;
  localparam int unsigned DefCntW     = 8;

endpackage

// File: rtl/spike_counter_bank.sv
// Bank of per-neuron saturating spike counters with synchronous clear and count enable.
module spike_counter_bank
  import snn_pkg::*;
#(
  parameter int unsigned N_NEURONS = DefNNeurons,
  parameter int unsigned CNT_W     = DefCntW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       en,
  input  logic [N_NEURONS-1:0]       spike_in,
  output logic [N_NEURONS*CNT_W-1:0] counts
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [N_NEURONS*CNT_W-1:0] counts_q, counts_d;

  always_comb begin
    counts_d = counts_q;
    if (clr) begin
      counts_d = '0;
    end else if (en) begin
      for (int i = 0; i < int'(N_NEURONS); i++) begin
        // Hold at full scale instead of wrapping back to zero.
        if (spike_in[i] && (counts_q[i*CNT_W +: CNT_W] != CntMax)) begin
          counts_d[i*CNT_W +: CNT_W] = counts_q[i*CNT_W +: CNT_W] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counts_q <= '0;
    end else begin
      counts_q <= counts_d;
    end
  end

  assign counts = counts_q;

endmodule

// File: rtl/spike_count_decoder.sv
// Counts output spikes over a fixed window, then scans for the most active neuron and
// reports its index and count with a one-cycle valid pulse.
module spike_count_decoder
  import snn_pkg::*;
#(
  parameter int unsigned N_NEURONS = DefNNeurons,
  parameter int unsigned WINDOW    = DefWindow,
  parameter int unsigned CNT_W     = DefCntW
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [N_NEURONS-1:0]          spike_in,
  output logic                          busy,
  output logic                          valid,
  output logic [$clog2(N_NEURONS)-1:0]  class_out,
  output logic [CNT_W-1:0]              class_count,
  output logic                          no_spike
);

  localparam int unsigned CLS_W = $clog2(N_NEURONS);
  localparam int unsigned TS_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  localparam logic [TS_W-1:0]  TsLast  = TS_W'(WINDOW - 1);
  localparam logic [CLS_W-1:0] IdxLast = CLS_W'(N_NEURONS - 1);

  state_e                     state_q, state_d;
  logic [TS_W-1:0]            ts_q, ts_d;
  logic [CLS_W-1:0]           idx_q, idx_d;
  logic [CLS_W-1:0]           best_idx_q, best_idx_d;
  logic [CNT_W-1:0]           best_cnt_q, best_cnt_d;
  logic                       valid_q, valid_d;
  logic [CLS_W-1:0]           class_q, class_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       no_spike_q, no_spike_d;

  logic                       cnt_clr, cnt_en;
  logic [N_NEURONS*CNT_W-1:0] counts;
  logic [CNT_W-1:0]           cur_cnt;
  logic [CLS_W-1:0]           cand_idx;
  logic [CNT_W-1:0]           cand_cnt;

  spike_counter_bank #(
    .N_NEURONS(N_NEURONS),
    .CNT_W    (CNT_W)
  ) u_counter_bank (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .spike_in(spike_in),
    .counts  (counts)
  );

  // Strict compare so ties keep the lower index already held in best.
  always_comb begin
    cur_cnt  = counts[int'(idx_q)*CNT_W +: CNT_W];
    cand_idx = best_idx_q;
    cand_cnt = best_cnt_q;
    if (cur_cnt > best_cnt_q) begin
      cand_idx = idx_q;
      cand_cnt = cur_cnt;
    end
  end

  always_comb begin
    state_d    = state_q;
    ts_d       = ts_q;
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
    valid_d    = 1'b0;
    class_d    = class_q;
    count_d    = count_q;
    no_spike_d = no_spike_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          cnt_clr = 1'b1;
          ts_d    = '0;
          state_d = StCount;
        end
      end
      StCount: begin
        cnt_en = 1'b1;
        ts_d   = ts_q + 1'b1;
        if (ts_q == TsLast) begin
          idx_d      = '0;
          best_idx_d = '0;
          best_cnt_d = '0;
          state_d    = StScan;
        end
      end
      StScan: begin
        idx_d      = idx_q + 1'b1;
        best_idx_d = cand_idx;
        best_cnt_d = cand_cnt;
        if (idx_q == IdxLast) begin
          class_d    = cand_idx;
          count_d    = cand_cnt;
          no_spike_d = (cand_cnt == '0);
          valid_d    = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ts_q       <= '0;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
      valid_q    <= 1'b0;
      class_q    <= '0;
      count_q    <= '0;
      no_spike_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_cnt_q <= best_cnt_d;
      valid_q    <= valid_d;
      class_q    <= class_d;
      count_q    <= count_d;
      no_spike_q <= no_spike_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign valid       = valid_q;
  assign class_out   = class_q;
  assign class_count = count_q;
  assign no_spike    = no_spike_q;

endmodule

// File: tb/tb_spike_count_decoder.sv
// Scoreboard bench: driver models each window from its spike pattern, monitor checks results.
module tb_spike_count_decoder;

  localparam int unsigned N     = 8;
  localparam int unsigned W     = 8;
  localparam int unsigned C     = 3;
  localparam int unsigned CLS_W = 3;
  localparam int          Lat   = W + N;
  localparam int          CMax  = (1 << C) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [N-1:0]     spike_in;
  logic             busy;
  logic             valid;
  logic [CLS_W-1:0] class_out;
  logic [C-1:0]     class_count;
  logic             no_spike;

  spike_count_decoder #(
    .N_NEURONS(N),
    .WINDOW   (W),
    .CNT_W    (C)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .spike_in   (spike_in),
    .busy       (busy),
    .valid      (valid),
    .class_out  (class_out),
    .class_count(class_count),
    .no_spike   (no_spike)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cls;
    int cnt;
    int nos;
    int t0;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [N-1:0] pat[W];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops on every valid, otherwise checks that results hold.
  initial begin
    int   hold_cls, hold_cnt, hold_nos;
    bit   prev_valid;
    exp_t e;
    hold_cls = 0; hold_cnt = 0; hold_nos = 0; prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_cls = 0; hold_cnt = 0; hold_nos = 0; prev_valid = 1'b0;
      end else begin
        if (valid) begin
          check("valid_one_cycle", int'(prev_valid), 0);
          check("busy_in_valid", int'(busy), 0);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got valid=1, expected no result (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            check("class_out", int'(class_out), e.cls);
            check("class_count", int'(class_count), e.cnt);
            check("no_spike", int'(no_spike), e.nos);
            check("latency", cyc - e.t0, Lat);
            hold_cls = e.cls; hold_cnt = e.cnt; hold_nos = e.nos;
          end
        end else begin
          check("hold_class", int'(class_out), hold_cls);
          check("hold_count", int'(class_count), hold_cnt);
          check("hold_no_spike", int'(no_spike), hold_nos);
        end
        prev_valid = valid;
      end
    end
  end

  // Reference: per-neuron popcount over the window, clipped, then first maximum wins.
  task automatic model_push();
    int   cnt[N];
    exp_t e;
    for (int i = 0; i < int'(N); i++) begin
      cnt[i] = 0;
      for (int t = 0; t < int'(W); t++) if (pat[t][i]) cnt[i]++;
      if (cnt[i] > CMax) cnt[i] = CMax;
    end
    e.cls = 0;
    e.cnt = 0;
    for (int i = 0; i < int'(N); i++) begin
      if (cnt[i] > e.cnt) begin
        e.cnt = cnt[i];
        e.cls = i;
      end
    end
    e.nos = (e.cnt == 0) ? 1 : 0;
    e.t0  = cyc;
    sb.push_back(e);
  endtask

  task automatic fill(input int mode);
    int thr;
    thr = $urandom_range(0, 4);
    for (int t = 0; t < int'(W); t++) begin
      case (mode)
        0: pat[t] = 8'h04;
        1: pat[t] = (t % 2 == 0) ? 8'hFF : 8'h00;
        2: pat[t] = 8'h00;
        3: pat[t] = (t < int'(W) - 1) ? 8'h22 : 8'h20;
        default: begin
          for (int i = 0; i < int'(N); i++) pat[t][i] = ($urandom_range(0, 3) < thr);
        end
      endcase
    end
  endtask

  // Entered #1 after a clock edge with the DUT idle or showing valid.
  task automatic launch(input bit mid_start, input bit abort);
    start    = 1'b1;
    spike_in = N'($urandom);
    @(posedge clk); #1;
    if (!abort) model_push();
    check("busy_after_start", int'(busy), 1);
    for (int t = 0; t < int'(W); t++) begin
      spike_in = pat[t];
      start    = (mid_start && t == 1);
      @(posedge clk); #1;
    end
    start    = 1'b0;
    spike_in = N'($urandom);
    if (abort) begin
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_busy", int'(busy), 0);
      check("abort_valid", int'(valid), 0);
      check("abort_class_out", int'(class_out), 0);
      check("abort_class_count", int'(class_count), 0);
      check("abort_no_spike", int'(no_spike), 0);
      reset = 1'b0;
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!valid && n < 100) begin
      spike_in = N'($urandom);
      @(posedge clk); #1;
      n++;
    end
    if (!valid) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got no valid in %0d cycles, expected one", n);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      spike_in = N'($urandom);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    spike_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_class_out", int'(class_out), 0);
    check("reset_class_count", int'(class_count), 0);
    check("reset_no_spike", int'(no_spike), 0);
    reset = 1'b0;
    idle(3);

    for (int m = 0; m < 4; m++) begin
      fill(m);
      launch(1'b0, 1'b0);
      wait_valid();
      idle(2);
    end

    fill(4);
    launch(1'b1, 1'b0);
    wait_valid();
    idle(1);

    // Back-to-back: second start lands in the valid cycle of the first.
    fill(4);
    launch(1'b0, 1'b0);
    wait_valid();
    fill(0);
    launch(1'b0, 1'b0);
    wait_valid();
    idle(2);

    fill(4);
    launch(1'b0, 1'b1);
    idle(3);
    check("abort_no_pending", sb.size(), 0);

    for (int r = 0; r < 20; r++) begin
      fill(4);
      launch(1'b0, 1'b0);
      wait_valid();
      idle($urandom_range(0, 3));
    end

    idle(4);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
